instr_mem_loadable: RTL and testbench
=====================================

// Module: instr_mem_loadable
// PURPOSE
//  Parametrised, clocked instruction memory for the CPU fetch stage: byte-addressed storage, big-endian word fetch.
//  Replaces hard-coded instruction tables: a byte-serial loader port fills memory at run time.
//  Fetch is a req/valid handshake with registered 1-cycle read latency.
//  Misaligned or out-of-range fetches are flagged and return a NOP.
// PARAMETERS
//  MEM_BYTES   128  storage size in bytes; multiple of 4, >= 8
//  ADDR_W      32   fetch address width
//  NOP_INSTR   32'h0000_0000  word returned on faulted fetch
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous, active-low reset
//  load_start   in   1       pulse: begin (re)load at byte 0
//  load_valid   in   1       load_byte valid this cycle
//  load_byte    in   8       next program byte
//  load_last    in   1       qualifies final byte (with load_valid)
//  load_ready   out  1       loader accepts a byte this cycle
//  load_count   out  $clog2(MEM_BYTES)+1  bytes written in current/last load
//  fetch_req    in   1       fetch request
//  fetch_addr   in   ADDR_W  byte address of instruction
//  fetch_ready  out  1       fetch accepted this cycle when fetch_req=1
//  fetch_valid  out  1       response valid (1 cycle after acceptance)
//  fetch_instr  out  32      {mem[a],mem[a+1],mem[a+2],mem[a+3]}
//  fetch_fault  out  1       response was misaligned/out of range
//  busy         out  1       loader active (state LOAD)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, load ptr=0, load_count=0, fetch_valid=0, fetch_instr=0,
//   fetch_fault=0. Memory array is NOT cleared; contents survive reset.
//  FSM: IDLE --load_start--> LOAD; LOAD --accepted byte with load_last, or ptr==MEM_BYTES-1--> RUN;
//   RUN --load_start--> LOAD. load_start in LOAD restarts: ptr=0, load_count=0.
//  Entering LOAD: ptr=0, load_count=0. load_ready = (state==LOAD).
//  Byte accept: load_valid & load_ready -> mem[ptr]<=load_byte, ptr++, load_count++.
//  After MEM_BYTES bytes: auto-exit to RUN; extra bytes are never accepted (load_ready=0 outside LOAD).
//  load_valid/load_last outside LOAD: ignored. load_last without load_valid: ignored.
//  fetch_ready = (state!=LOAD) & ~load_start. load_start wins a same-cycle fetch; the fetch is not accepted.
//  Accepted fetch at cycle N -> cycle N+1: fetch_valid=1, fetch_instr, fetch_fault registered.
//   No accept at N -> fetch_valid=0 at N+1, fetch_instr/fetch_fault hold previous values.
//  Back-to-back fetches every cycle are supported (throughput 1/cycle).
//  Fault: fetch_addr[1:0]!=0 OR fetch_addr > MEM_BYTES-4 (compare at full ADDR_W, no wrap) ->
//   fetch_instr=NOP_INSTR, fetch_fault=1. Otherwise fetch_fault=0.
//  Fetch in IDLE is legal; it returns the retained/uninitialised contents.
//  Memory write and read never happen in the same cycle (fetch blocked in LOAD), so no bypass is needed.
//  Reset mid-load: FSM -> IDLE; bytes already written stay; load_count reads 0.
//  busy = (state==LOAD).
// TESTING
//  T1 reset: rst_n=0 mid-cycle -> all outputs 0 immediately; busy=0; fetch_ready=1.
//  T2 load: load_start, stream 8 bytes 01 4B 60 20 01 AC A8 22 with load_last on the 8th byte ->
//     load_count=8, busy falls the cycle after the 8th byte, state RUN.
//  T3 fetch: after T2, fetch 0x0 then 0x4 in back-to-back cycles -> valid on the next two cycles with
//     32'h014B6020, then 32'h01ACA822; fault=0 on both.
//  T4 faults: fetch 0x2 -> NOP_INSTR, fault=1; fetch MEM_BYTES (0x80) -> NOP, fault=1;
//     fetch 0x7C -> real word, fault=0.
//  T5 overflow: stream MEM_BYTES+3 bytes without load_last -> exit after byte 128, load_count=128,
//     load_ready=0 for the extra 3 bytes; mem[0] is unchanged by them.
//  T6 collisions: fetch_req with load_start -> fetch_ready=0, no fetch_valid next cycle;
//     rst_n pulse after 5 of 8 bytes -> IDLE, load_count=0; fetch 0x0 still returns the first 4 new bytes.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: byte-addressed instruction memory for the fetch stage.
// A byte-serial loader fills the array at run time. Fetches return a big-endian
// word one cycle after acceptance. Misaligned or out-of-range fetches are flagged
// and return NOP_INSTR. The storage array has no reset, so a program loaded
// before a reset is still there afterwards.

module instr_mem_loadable #(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic [7:0]                 load_byte,
    input  logic                       load_last,
    output logic                       load_ready,
    output logic [$clog2(MEM_BYTES):0] load_count,
    input  logic                       fetch_req,
    input  logic [ADDR_W-1:0]          fetch_addr,
    output logic                       fetch_ready,
    output logic                       fetch_valid,
    output logic [31:0]                fetch_instr,
    output logic                       fetch_fault,
    output logic                       busy
);

    localparam int unsigned PTR_W = $clog2(MEM_BYTES);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } loaderState_e;

    loaderState_e r_state;
    loaderState_e w_nextState;

    logic [7:0]       r_mem [MEM_BYTES];
    logic [PTR_W-1:0] r_loadPtr;
    logic [CNT_W-1:0] r_loadCount;

    logic             w_byteAccept;
    logic             w_lastByte;
    logic             w_fetchAccept;
    logic             w_misaligned;
    logic             w_outOfRange;
    logic             w_fault;
    logic [PTR_W-1:0] w_idx0;
    logic [PTR_W-1:0] w_idx1;
    logic [PTR_W-1:0] w_idx2;
    logic [PTR_W-1:0] w_idx3;
    logic [31:0]      w_memWord;

    // A restart pulse takes priority over a byte in the same cycle. The pointer
    // is being cleared, so that byte is dropped rather than written.
    assign w_byteAccept = load_valid & load_ready & ~load_start;
    // The load finishes on a byte tagged last, or when the final location is written.
    assign w_lastByte   = w_byteAccept &
                          (load_last | (r_loadPtr == PTR_W'(MEM_BYTES - 1)));
    assign w_fetchAccept = fetch_req & fetch_ready;
    assign load_count    = r_loadCount;

    // Loader state register: reset always returns the FSM to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: load_start (re)enters LOAD from any state.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                if (load_start) begin
                    w_nextState = LOAD;
                end else if (w_lastByte) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (load_start) begin
                    w_nextState = LOAD;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // FSM outputs: the loader owns the array while loading, so fetches are held off then.
    always_comb begin
        load_ready  = 1'b0;
        busy        = 1'b0;
        fetch_ready = 1'b0;
        if (r_state == LOAD) begin
            load_ready = 1'b1;
            busy       = 1'b1;
        end
        fetch_ready = (r_state != LOAD) & ~load_start;
    end

    // Load pointer and byte counter. Both restart on load_start. Each accepted byte advances both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loadPtr   <= '0;
            r_loadCount <= '0;
        end else if (load_start) begin
            r_loadPtr   <= '0;
            r_loadCount <= '0;
        end else if (w_byteAccept) begin
            r_loadPtr   <= r_loadPtr + PTR_W'(1);
            r_loadCount <= r_loadCount + CNT_W'(1);
        end
    end

    // Storage write port. This block deliberately has no reset, so the program survives a reset.
    always_ff @(posedge clk) begin
        if (w_byteAccept) begin
            r_mem[r_loadPtr] <= load_byte;
        end
    end

    // Fetch decode: the fault check uses the full address width so large addresses cannot wrap into range.
    always_comb begin
        w_misaligned = |fetch_addr[1:0];
        w_outOfRange = fetch_addr > ADDR_W'(MEM_BYTES - 4);
        w_fault      = w_misaligned | w_outOfRange;
        w_idx0       = fetch_addr[PTR_W-1:0];
        w_idx1       = w_idx0 + PTR_W'(1);
        w_idx2       = w_idx0 + PTR_W'(2);
        w_idx3       = w_idx0 + PTR_W'(3);
        w_memWord    = {r_mem[w_idx0], r_mem[w_idx1], r_mem[w_idx2], r_mem[w_idx3]};
    end

    // Registered fetch response. The data and fault outputs hold their values when no fetch is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_instr <= 32'h0000_0000;
            fetch_fault <= 1'b0;
        end else begin
            fetch_valid <= w_fetchAccept;
            if (w_fetchAccept) begin
                fetch_instr <= w_fault ? NOP_INSTR : w_memWord;
                fetch_fault <= w_fault;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: directed bench for instr_mem_loadable.
// A byte-array model records every byte the loader should accept. Expected
// fetch responses are queued when a fetch is driven and are popped when the
// response cycle arrives.

module tb_instr_mem_loadable;

    localparam int          MEM_BYTES = 128;
    localparam logic [31:0] NOP       = 32'hDEAD_0013;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic [7:0]  load_count;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;
    logic        busy;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
    } fetchExp_t;

    fetchExp_t   expQ [$];
    logic [7:0]  tbMem [MEM_BYTES];
    bit          modelLoading;
    int          modelPtr;
    int          modelCount;
    logic [31:0] lastInstr;
    logic        lastFault;
    bit          monitorOn;
    int          passCount;
    int          totalChecks;

    instr_mem_loadable #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (32),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_count  (load_count),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault),
        .busy        (busy)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    endtask

    function automatic fetchExp_t predictFetch(input logic [31:0] addr);
        fetchExp_t e;
        if ((addr[1:0] != 2'b00) || (addr > 32'(MEM_BYTES - 4))) begin
            e.instr = NOP;
            e.fault = 1'b1;
        end else begin
            e.instr = {tbMem[addr], tbMem[addr + 1], tbMem[addr + 2], tbMem[addr + 3]};
            e.fault = 1'b0;
        end
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge, check the outputs, then advance the model.
    task automatic applyStimulus(input logic ls, input logic lv, input logic [7:0] lb,
                                 input logic ll, input logic fr, input logic [31:0] fa);
        bit fetchOk;
        @(negedge clk);
        checkOutput("busy", busy, modelLoading);
        checkOutput("load_count", load_count, modelCount);
        load_start = ls;
        load_valid = lv;
        load_byte  = lb;
        load_last  = ll;
        fetch_req  = fr;
        fetch_addr = fa;
        #1;
        fetchOk = !modelLoading && !ls;
        checkOutput("load_ready", load_ready, modelLoading);
        checkOutput("fetch_ready", fetch_ready, fetchOk);
        if (fr && fetchOk) expQ.push_back(predictFetch(fa));
        if (ls) begin
            modelLoading = 1'b1;
            modelPtr     = 0;
            modelCount   = 0;
        end else if (modelLoading && lv) begin
            tbMem[modelPtr] = lb;
            modelPtr++;
            modelCount++;
            if (ll || modelPtr == MEM_BYTES) modelLoading = 1'b0;
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    endtask

    // Assert reset mid-cycle. Every reset value must appear before the next clock edge.
    task automatic doReset(input string tag);
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b0;
        load_byte  = 8'h00;
        load_last  = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " load_count"}, load_count, 0);
        checkOutput({tag, " load_ready"}, load_ready, 0);
        checkOutput({tag, " fetch_valid"}, fetch_valid, 0);
        checkOutput({tag, " fetch_instr"}, fetch_instr, 0);
        checkOutput({tag, " fetch_fault"}, fetch_fault, 0);
        checkOutput({tag, " fetch_ready"}, fetch_ready, 1);
        modelLoading = 1'b0;
        modelPtr     = 0;
        modelCount   = 0;
        lastInstr    = 32'h0;
        lastFault    = 1'b0;
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor, sampled shortly after each rising edge. It checks every response and every hold cycle.
    always @(posedge clk) begin
        fetchExp_t e;
        #2;
        if (monitorOn) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("fetch_valid", fetch_valid, 1);
                checkOutput("fetch_instr", fetch_instr, e.instr);
                checkOutput("fetch_fault", fetch_fault, e.fault);
                lastInstr = e.instr;
                lastFault = e.fault;
            end else begin
                checkOutput("fetch_valid idle", fetch_valid, 0);
                checkOutput("fetch_instr hold", fetch_instr, lastInstr);
                checkOutput("fetch_fault hold", fetch_fault, lastFault);
            end
        end
    end

    // Directed sequence. The full-memory overflow load runs first so that every word has defined contents.
    initial begin
        logic [7:0] t2Bytes [8];
        logic [7:0] t6Bytes [5];
        t2Bytes = '{8'h01, 8'h4B, 8'h60, 8'h20, 8'h01, 8'hAC, 8'hA8, 8'h22};
        t6Bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11};
        passCount    = 0;
        totalChecks  = 0;
        monitorOn    = 1'b0;
        modelLoading = 1'b0;
        modelPtr     = 0;
        modelCount   = 0;
        lastInstr    = 32'h0;
        lastFault    = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) tbMem[i] = 8'h00;
        rst_n      = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_byte  = 8'h00;
        load_last  = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;

        // T1: asynchronous reset values.
        doReset("T1");
        monitorOn = 1'b1;
        idleCycle();

        // T5: MEM_BYTES+3 bytes with no last flag. The three extra bytes must be refused.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < MEM_BYTES + 3; i++) begin
            applyStimulus(1'b0, 1'b1, (i < MEM_BYTES) ? 8'(i * 7 + 3) : 8'hEE, 1'b0, 1'b0, 32'h0);
        end
        idleCycle();
        #1;
        checkOutput("T5 load_count", load_count, 128);
        checkOutput("T5 busy", busy, 0);
        checkOutput("T5 load_ready", load_ready, 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0);
        idleCycle();

        // T2: eight-byte program terminated by load_last.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, t2Bytes[i], (i == 7), 1'b0, 32'h0);
        end
        idleCycle();
        #1;
        checkOutput("T2 load_count", load_count, 8);
        checkOutput("T2 busy", busy, 0);

        // T3: back-to-back fetches of the first two words.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h4);
        idleCycle();
        idleCycle();

        // T4: misaligned, one past the end, last legal word, and a huge address.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h2);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'(MEM_BYTES));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h7C);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'hFFFF_FFFC);
        idleCycle();
        idleCycle();

        // T6: load_start beats a same-cycle fetch. A reset mid-load keeps the bytes already written.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, t6Bytes[i], 1'b0, 1'b0, 32'h0);
        end
        doReset("T6");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0);
        idleCycle();
        idleCycle();
        checkOutput("scoreboard drained", expQ.size(), 0);

        monitorOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule
